// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a registered one-hot grant.
// A grant is held until the owner raises Done, drops its request, or has held
// the resource for HOLD_MAX consecutive cycles. Priority then moves to the
// index just past the one that was served.
//
// Handshake: Valid=1 means GrantIdx/Grant name the current owner. The owner
// signals end of use with Done, which is only looked at while Valid=1. Req is
// level-sensitive and is not a valid/ready pair: a requester simply holds
// Req[i] high for as long as it wants the resource.
module rr_arbiter8 #(
   parameter int HOLD_MAX = 15
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] Req,
   input  logic       Done,
   output logic       Valid,
   output logic [2:0] GrantIdx,
   output logic [0:7] Grant,
   output logic       dbg_state,
   output logic [2:0] dbg_ptr
);

   localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t        state;
   logic [2:0]    ptr;
   logic [CW-1:0] cnt;

   logic [2:0]    pick;
   logic [2:0]    cand;
   logic          found;
   logic [0:7]    pick_dec;
   logic          timeout;
   logic          release_now;

   // Cyclic priority search starting at ptr; first requester found wins.
   always_comb begin
      pick  = 3'd0;
      cand  = 3'd0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cand = ptr + 3'(k);
         if (!found && Req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   // 3-to-8 decode of the selected index, loaded into Grant with GrantIdx.
   always_comb begin
      pick_dec       = '0;
      pick_dec[pick] = 1'b1;
   end

   // Timeout only exists when HOLD_MAX is non-zero.
   assign timeout     = (HOLD_MAX != 0) && (cnt == CW'(HOLD_MAX));
   assign release_now = Done || !Req[GrantIdx] || timeout;

   // Arbiter FSM with registered outputs, pointer and hold counter.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         ptr      <= 3'd0;
         cnt      <= '0;
         Valid    <= 1'b0;
         GrantIdx <= 3'd0;
         Grant    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|Req) begin
                  state    <= GRANT;
                  GrantIdx <= pick;
                  Grant    <= pick_dec;
                  Valid    <= 1'b1;
                  cnt      <= CW'(1);
               end
            end
            GRANT: begin
               if (release_now) begin
                  state    <= IDLE;
                  Valid    <= 1'b0;
                  Grant    <= '0;
                  GrantIdx <= 3'd0;
                  ptr      <= GrantIdx + 3'd1;
                  cnt      <= '0;
               end else if (cnt != {CW{1'b1}}) begin
                  // Saturates; only reachable when the timeout is disabled.
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;
   assign dbg_ptr   = ptr;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one resource among eight requesters and drives a one-hot grant bus with the same ordering as the team's 3-to-8 decoder output (Grant[0:7]). It picks one requester, holds the grant until the owner signals Done, drops its request, or hits a hold timeout, and then advances priority past the served index. It sits between the requesters and the shared datapath. GrantIdx is the 3-bit select; Grant is its decoded one-hot form.

## Interface
- HOLD_MAX, default 15: maximum consecutive cycles one grant may be held. 0 disables the timeout. Counter width is max(1, $clog2(HOLD_MAX+1)).

- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  [7:0]  request lines; Req[i] is requester i, level-sensitive.
- Done  input  1  owner releases the grant; sampled only while Valid=1.
- Valid  output  1  a grant is active (registered).
- GrantIdx  output  [2:0]  index of the granted requester (registered).
- Grant  output  [0:7]  one-hot grant; Grant[i]=1 iff Valid=1 and GrantIdx=i (registered).

## Operation
- State: FSM {IDLE, GRANT}, 3-bit priority pointer Ptr, hold counter Cnt.
- Reset (Reset=1 at an edge, in any state, overriding all other inputs):
  - state=IDLE, Ptr=0, Cnt=0;
  - Valid=0, GrantIdx=0, Grant=0.
- IDLE:
  - If Req==0, stay IDLE; outputs stay 0.
  - Otherwise select the first i with Req[i]=1, searching Ptr, Ptr+1, …, 7, 0, …, Ptr-1 (mod 8).
  - At the edge: state=GRANT, GrantIdx=i, Grant[i]=1, Valid=1, Cnt=1.
- GRANT, evaluated each cycle. Release if any of these holds:
  - Done=1;
  - Req[GrantIdx]=0;
  - HOLD_MAX≠0 and Cnt==HOLD_MAX.
- On release, at the edge: state=IDLE, Valid=0, Grant=0, GrantIdx=0, Ptr=GrantIdx+1 mod 8 (7 wraps to 0), Cnt=0.
- Otherwise stay in GRANT with outputs unchanged. Cnt increments, saturating at its maximum when HOLD_MAX=0.
- Simultaneous release conditions are a single release with identical effect.
- Requests from other indices during GRANT are ignored (no preemption).
- Done while in IDLE is ignored.
- Grant is always the 3-to-8 decode of GrantIdx gated by Valid. Grant is never multi-hot, and is all-zero when Valid=0.

## Timing
- Arbitration latency: a Req first seen in IDLE at edge N gives Valid=1 after edge N (visible in cycle N+1).
- Release latency: a release condition seen at edge M gives Valid=0 in cycle M+1.
- Every release is followed by exactly one idle cycle, so back-to-back grants are separated by one Valid=0 cycle.
- Minimum grant length is 1 cycle (Done asserted in the first Valid cycle).
- With HOLD_MAX=H>0 and no Done, Valid stays high exactly H cycles.
- Fairness: with all eight requesting continuously, each index is granted once per 8 grants, in ascending cyclic order.
- All outputs come directly from registers. There is no combinational path from Req or Done to any output.

## Test plan
- Reset: hold Req=8'hFF and Reset=1 for 2 cycles. Required: Valid=0, GrantIdx=0, Grant=0 throughout. After Reset falls, the first grant is index 0 one cycle later.
- Single requester: Req=8'h04. Required: next cycle Valid=1, GrantIdx=2, Grant[2]=1 and all other bits 0. Pulse Done for 1 cycle: next cycle Valid=0; the next grant search starts at index 3.
- Full round-robin: Req=8'hFF with Done pulsed on every grant cycle. Required: GrantIdx sequence 0,1,2,3,4,5,6,7,0, one idle cycle between grants, and Grant always one-hot when Valid=1.
- Wrap-around: reach Ptr=6 by granting and releasing index 5, then set Req=8'h22 (indices 1 and 5). Required: search order 6,7,0,1 grants index 1, then index 5 after release.
- Timeout: HOLD_MAX=4, Req=8'h08 held, Done=0. Required: Valid=1 with GrantIdx=3 for exactly 4 cycles, then 1 idle cycle, then index 3 re-granted as the sole requester. A second case drops Req[3] mid-grant: required release on the following cycle.
- Reset mid-grant: while GrantIdx=5 and Valid=1, assert Reset for 1 cycle. Required: next cycle Valid=0, Grant=0, Ptr=0. With Req=8'h21 the next grant goes to index 0, not 5.
